// File: rtl/wb_stage_if.sv
// Writeback stage bus bundle.
// Carries the retiring instruction from the memory stage and the resulting
// register-file write port plus its bypass copy.
interface wb_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  // memory stage -> writeback stage
  logic                  in_valid;
  logic                  in_reg_wr;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [1:0]            in_wb_sel;
  logic [XLEN-1:0]       in_alu_result;
  logic [XLEN-1:0]       in_mem_rdata;
  logic [2:0]            in_funct3;
  logic [XLEN-1:0]       in_pc_plus_4;

  // writeback stage -> register file and bypass network
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_reg;
  logic [XLEN-1:0]       wr_data;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_reg;
  logic [XLEN-1:0]       fwd_data;

  // Upstream/consumer side: presents instructions, observes the write port.
  modport master (
    output in_valid, in_reg_wr, in_rd, in_wb_sel,
           in_alu_result, in_mem_rdata, in_funct3, in_pc_plus_4,
    input  wr_en, wr_reg, wr_data, fwd_valid, fwd_reg, fwd_data
  );

  // The writeback stage itself.
  modport slave (
    input  in_valid, in_reg_wr, in_rd, in_wb_sel,
           in_alu_result, in_mem_rdata, in_funct3, in_pc_plus_4,
    output wr_en, wr_reg, wr_data, fwd_valid, fwd_reg, fwd_data
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: picks the result source, aligns and extends load data,
// screens out faulting loads and x0 writes, and registers one retiring
// instruction per cycle onto the register-file write port. Also keeps the
// retired-instruction counter.
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  wb_stage_if.slave        bus,
  output logic             load_fault,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [1:0]            lsb;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [XLEN-1:0]       ld_data;
  logic [XLEN-1:0]       src_data;
  logic                  fault_raw;
  logic                  fault_c;
  logic                  capture_c;

  logic                  wr_en_d,      wr_en_q;
  logic [REG_ADDR_W-1:0] wr_reg_d,     wr_reg_q;
  logic [XLEN-1:0]       wr_data_d,    wr_data_q;
  logic                  load_fault_d, load_fault_q;
  logic                  retire_d,     retire_q;
  logic [CNT_W-1:0]      instret_d,    instret_q;

  assign lsb = bus.in_alu_result[1:0];

  // Load alignment: pull the addressed byte/halfword down to bit 0 and extend.
  always_comb begin
    ld_byte = 8'(bus.in_mem_rdata >> {lsb, 3'b000});
    ld_half = 16'(bus.in_mem_rdata >> {lsb[1], 4'b0000});
    ld_data = bus.in_mem_rdata;
    case (bus.in_funct3)
      F3_LB:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = bus.in_mem_rdata;
    endcase
  end

  // Source select and fault detection; faults only matter for rd writers.
  always_comb begin
    src_data  = bus.in_alu_result;
    fault_raw = 1'b0;
    case (bus.in_wb_sel)
      SEL_ALU: src_data = bus.in_alu_result;
      SEL_PC4: src_data = bus.in_pc_plus_4;
      SEL_MEM: begin
        src_data = ld_data;
        case (bus.in_funct3)
          F3_LB, F3_LBU: fault_raw = 1'b0;
          F3_LH, F3_LHU: fault_raw = lsb[0];
          F3_LW:         fault_raw = (lsb != 2'b00);
          default:       fault_raw = 1'b1;
        endcase
      end
      default: fault_raw = 1'b1;
    endcase
    fault_c = bus.in_reg_wr & fault_raw;
  end

  // Next-state for the stage register; wr_reg/wr_data hold when no write.
  always_comb begin
    capture_c    = bus.in_valid & ~flush;
    wr_en_d      = capture_c & bus.in_reg_wr & (bus.in_rd != '0) & ~fault_c;
    wr_reg_d     = wr_reg_q;
    wr_data_d    = wr_data_q;
    if (wr_en_d) begin
      wr_reg_d  = bus.in_rd;
      wr_data_d = src_data;
    end
    load_fault_d = capture_c & fault_c;
    retire_d     = capture_c & ~fault_c;
    // The held instruction is counted as it leaves the stage, so a reset
    // while it is held drops its count as well as its write.
    instret_d    = instret_q + CNT_W'(retire_q);
  end

  // Stage register and retired counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q      <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
      load_fault_q <= 1'b0;
      retire_q     <= 1'b0;
      instret_q    <= '0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
      load_fault_q <= load_fault_d;
      retire_q     <= retire_d;
      instret_q    <= instret_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_reg    = wr_reg_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.fwd_valid = wr_en_q;
  assign bus.fwd_reg   = wr_reg_q;
  assign bus.fwd_data  = wr_data_q;
  assign load_fault    = load_fault_q;
  assign instret       = instret_q;

endmodule
